// File: rtl/multi_fifo_push_arb.sv
// Round-robin push arbiter sharing one multi-push FIFO among R requesters.
// Granted bursts are packed contiguously onto push lanes 0..M-1. The block
// also provides starvation protection and the FIFO flush sequence.
// Optional: define MULTI_FIFO_PUSH_ARB_STAT_EN to add the stall_cnt output.
module multi_fifo_push_arb #(
    parameter type         T       = logic [7:0],
    parameter int unsigned R       = 4,
    parameter int unsigned M       = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MAXWAIT = 8,
    localparam int unsigned DB     = $clog2(DEPTH),
    localparam int unsigned NB     = $clog2(M + 1),
    localparam int unsigned RB     = (R > 1) ? $clog2(R) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [R-1:0]            req_valid,
    input  logic [R-1:0][NB-1:0]    req_num,
    input  T     [R-1:0][M-1:0]     req_data,
    output logic [R-1:0]            req_ready,
    output logic [M-1:0]            fifo_push,
    output T     [M-1:0]            fifo_datain,
    input  logic [DB:0]             fifo_entry_count,
    input  logic                    flush_req,
    output logic                    fifo_clear,
    output logic                    flush_done,
    output logic                    busy
`ifdef MULTI_FIFO_PUSH_ARB_STAT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int unsigned WB = $clog2(MAXWAIT + 1);
    localparam int unsigned LB = (M > 1) ? $clog2(M) : 1;

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StHold  = 2'd1;
    localparam logic [1:0] StClear = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [RB-1:0]             rr_ptr_q, rr_ptr_d;
    logic [R-1:0][WB-1:0]      wait_q, wait_d;
    logic                      flush_done_q, flush_done_d;

    logic [R-1:0]              elig;
    logic [R-1:0]              urgent;
    logic [R-1:0]              grant;
    logic [M-1:0]              push_c;
    T     [M-1:0]              datain_c;
    logic [RB-1:0]             start_idx;
    logic [RB-1:0]             idx;
    logic [RB-1:0]             last_idx;
    logic [LB-1:0]             lane;
    logic                      urgent_mode;
    logic                      stop_scan;
    logic                      any_grant;
    logic                      run;
    int                        lanes_left;
    int                        space_left;
    int                        total;
    int                        num;
    int                        free_c;

    assign run = (state_q == StRun) && !rst;

    // Eligibility (legal burst size) and urgency per requester.
    always_comb begin
        elig   = '0;
        urgent = '0;
        for (int k = 0; k < R; k++) begin
            elig[k]   = req_valid[k] && (req_num[k] != '0) && (int'(req_num[k]) <= int'(M));
            urgent[k] = elig[k] && (wait_q[k] == WB'(MAXWAIT));
        end
    end

    // Round-robin scan with urgent override; packs granted bursts onto lanes from 0.
    always_comb begin
        grant       = '0;
        datain_c    = '0;
        push_c      = '0;
        total       = 0;
        num         = 0;
        lane        = '0;
        idx         = '0;
        any_grant   = 1'b0;
        stop_scan   = 1'b0;
        urgent_mode = 1'b0;
        last_idx    = rr_ptr_q;
        start_idx   = rr_ptr_q;
        lanes_left  = int'(M);
        free_c      = int'(DEPTH) - int'(fifo_entry_count);
        if (free_c < 0) free_c = 0;
        space_left  = free_c;

        // First urgent requester at or after rr_ptr becomes the scan start.
        for (int i = 0; i < R; i++) begin
            idx = RB'((int'(rr_ptr_q) + i) % int'(R));
            if (!urgent_mode && urgent[idx]) begin
                urgent_mode = 1'b1;
                start_idx   = idx;
            end
        end

        for (int i = 0; i < R; i++) begin
            idx = RB'((int'(start_idx) + i) % int'(R));
            if (elig[idx] && !stop_scan) begin
                num = int'(req_num[idx]);
                if (num <= lanes_left && num <= space_left) begin
                    grant[idx] = 1'b1;
                    for (int j = 0; j < M; j++) begin
                        if (j < num && (total + j) < int'(M)) begin
                            lane           = LB'(total + j);
                            datain_c[lane] = req_data[idx][j];
                        end
                    end
                    total      = total + num;
                    lanes_left = lanes_left - num;
                    space_left = space_left - num;
                    last_idx   = idx;
                    any_grant  = 1'b1;
                end else if (urgent_mode && i == 0) begin
                    // A starving requester that does not fit blocks everyone else.
                    stop_scan = 1'b1;
                end
            end
        end

        for (int l = 0; l < M; l++) begin
            push_c[l] = (l < total);
        end
    end

    // Outputs, gated off outside RUN and while reset is asserted.
    always_comb begin
        req_ready   = run ? grant : '0;
        fifo_push   = run ? push_c : '0;
        fifo_datain = run ? datain_c : '0;
        fifo_clear  = !rst && (state_q == StClear);
        busy        = !rst && (state_q != StRun);
        flush_done  = flush_done_q;
    end

    // Next-state: flush sequencing, round-robin pointer and wait counters.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        wait_d       = wait_q;
        flush_done_d = 1'b0;
        case (state_q)
            StRun: begin
                if (flush_req) state_d = StHold;
                if (any_grant) rr_ptr_d = RB'((int'(last_idx) + 1) % int'(R));
                for (int k = 0; k < R; k++) begin
                    if (grant[k]) begin
                        wait_d[k] = '0;
                    end else if (elig[k] && wait_q[k] != WB'(MAXWAIT)) begin
                        wait_d[k] = wait_q[k] + WB'(1);
                    end
                end
            end
            StHold: begin
                state_d = StClear;
            end
            StClear: begin
                state_d      = StRun;
                rr_ptr_d     = '0;
                wait_d       = '0;
                flush_done_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            rr_ptr_q     <= '0;
            wait_q       <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            wait_q       <= wait_d;
            flush_done_q <= flush_done_d;
        end
    end

`ifdef MULTI_FIFO_PUSH_ARB_STAT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of RUN cycles where some eligible requester lost.
    always_comb begin
        stall_d = stall_q;
        if (state_q == StClear) begin
            stall_d = '0;
        end else if (state_q == StRun && |(elig & ~grant) && stall_q != 16'hffff) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_multi_fifo_push_arb.sv
// Directed self-checking bench for multi_fifo_push_arb (R=4, M=4, DEPTH=16, MAXWAIT=8).
module tb_multi_fifo_push_arb;

    localparam int R = 4;
    localparam int M = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [R-1:0]           req_valid;
    logic [R-1:0][2:0]      req_num;
    logic [R-1:0][M-1:0][7:0] req_data;
    logic [R-1:0]           req_ready;
    logic [M-1:0]           fifo_push;
    logic [M-1:0][7:0]      fifo_datain;
    logic [4:0]             fifo_entry_count;
    logic                   flush_req;
    logic                   fifo_clear;
    logic                   flush_done;
    logic                   busy;
`ifdef MULTI_FIFO_PUSH_ARB_STAT_EN
    logic [15:0]            stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_fifo_push_arb dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_num          (req_num),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_push        (fifo_push),
        .fifo_datain      (fifo_datain),
        .fifo_entry_count (fifo_entry_count),
        .flush_req        (flush_req),
        .fifo_clear       (fifo_clear),
        .flush_done       (flush_done),
        .busy             (busy)
`ifdef MULTI_FIFO_PUSH_ARB_STAT_EN
        ,
        .stall_cnt        (stall_cnt)
`endif
    );

    // Requester k element j carries 16*(k+1)+j.
    task automatic set_req(input int k, input logic v, input int n);
        req_valid[k] = v;
        req_num[k]   = 3'(n);
        for (int j = 0; j < M; j++) req_data[k][j] = 8'(16 * (k + 1) + j);
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < R; k++) set_req(k, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush_req = 1'b0;
        fifo_entry_count = 5'd0;
        for (int k = 0; k < R; k++) set_req(k, 1'b1, 1);
        #2;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (fifo_push !== 4'b0000) begin errors++; $display("FAIL reset_push got %b want 0000", fifo_push); end
        checks++; if ({busy, fifo_clear, flush_done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {busy, fifo_clear, flush_done}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
    endtask

    task automatic test_basic_pack();
        @(negedge clk);
        set_req(0, 1'b1, 2);
        set_req(1, 1'b1, 2);
        #1;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL t1_ready got %b want 0011", req_ready); end
        checks++; if (fifo_push !== 4'b1111) begin errors++; $display("FAIL t1_push got %b want 1111", fifo_push); end
        checks++; if (fifo_datain !== 32'h21201110) begin errors++; $display("FAIL t1_data got %h want 21201110", fifo_datain); end
    endtask

    task automatic test_space_skip();
        @(negedge clk);
        fifo_entry_count = 5'd14;
        set_req(0, 1'b1, 3);
        set_req(1, 1'b1, 2);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL t2_ready got %b want 0010", req_ready); end
        checks++; if (fifo_push !== 4'b0011) begin errors++; $display("FAIL t2_push got %b want 0011", fifo_push); end
        checks++; if (fifo_datain !== 32'h00002120) begin errors++; $display("FAIL t2_data got %h want 00002120", fifo_datain); end
    endtask

    task automatic test_urgent();
        // wait0 climbs from 1 to 8 while req1 keeps winning.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            #1;
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL t3_climb%0d got %b want 0010", c, req_ready); end
        end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t3_block_ready got %b want 0000", req_ready); end
        checks++; if (fifo_push !== 4'b0000) begin errors++; $display("FAIL t3_block_push got %b want 0000", fifo_push); end
        @(negedge clk);
        fifo_entry_count = 5'd13;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t3_urgent_ready got %b want 0001", req_ready); end
        checks++; if (fifo_push !== 4'b0111) begin errors++; $display("FAIL t3_urgent_push got %b want 0111", fifo_push); end
        checks++; if (fifo_datain !== 32'h00121110) begin errors++; $display("FAIL t3_urgent_data got %h want 00121110", fifo_datain); end
        // wait0 now 0: req0 no longer blocks, req1 wins from rr_ptr=1.
        @(negedge clk);
        fifo_entry_count = 5'd14;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL t3_after got %b want 0010", req_ready); end
    endtask

    task automatic test_lane_skip();
        @(negedge clk);
        clear_reqs();
        fifo_entry_count = 5'd0;
        set_req(2, 1'b1, 1);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL t4_setup got %b want 0100", req_ready); end
        @(negedge clk);
        clear_reqs();
        set_req(3, 1'b1, 1);
        set_req(0, 1'b1, 4);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t4_ready got %b want 1000", req_ready); end
        checks++; if (fifo_push !== 4'b0001) begin errors++; $display("FAIL t4_push got %b want 0001", fifo_push); end
        checks++; if (fifo_datain !== 32'h00000040) begin errors++; $display("FAIL t4_data got %h want 00000040", fifo_datain); end
        // rr_ptr is 0: req0 goes first, req1 (4) no longer fits.
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 1);
        set_req(1, 1'b1, 4);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t4_rr got %b want 0001", req_ready); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 1);
        set_req(2, 1'b1, 0);
        set_req(3, 1'b1, 5);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ill_ready got %b want 0001", req_ready); end
        checks++; if (fifo_datain !== 32'h00000010) begin errors++; $display("FAIL ill_data got %h want 00000010", fifo_datain); end
        @(negedge clk);
        set_req(0, 1'b0, 1);
        set_req(3, 1'b1, 7);
        #1;
        checks++; if ({req_ready, fifo_push} !== 8'h00) begin errors++; $display("FAIL ill_none got %h want 00", {req_ready, fifo_push}); end
    endtask

    task automatic test_flush();
        // t: rr_ptr=1, all request 2 entries, flush pulses.
        @(negedge clk);
        for (int k = 0; k < R; k++) set_req(k, 1'b1, 2);
        flush_req = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL fl_t_ready got %b want 0110", req_ready); end
        checks++; if (fifo_datain !== 32'h31302120) begin errors++; $display("FAIL fl_t_data got %h want 31302120", fifo_datain); end
        // t+1: HOLD; flush_req held high must be ignored.
        @(negedge clk);
        #1;
        checks++; if ({req_ready, fifo_push} !== 8'h00) begin errors++; $display("FAIL fl_hold_grant got %h want 00", {req_ready, fifo_push}); end
        checks++; if ({busy, fifo_clear} !== 2'b10) begin errors++; $display("FAIL fl_hold_ctrl got %b want 10", {busy, fifo_clear}); end
        // t+2: CLEAR.
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        checks++; if ({busy, fifo_clear, req_ready} !== 6'b110000) begin errors++; $display("FAIL fl_clear got %b want 110000", {busy, fifo_clear, req_ready}); end
        // t+3: RUN, done pulse, rr_ptr back at 0.
        @(negedge clk);
        #1;
        checks++; if ({flush_done, busy, fifo_clear} !== 3'b100) begin errors++; $display("FAIL fl_done got %b want 100", {flush_done, busy, fifo_clear}); end
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL fl_resume got %b want 0011", req_ready); end
        @(negedge clk);
        #1;
        checks++; if ({flush_done, busy} !== 2'b00) begin errors++; $display("FAIL fl_after got %b want 00", {flush_done, busy}); end
        checks++; if (req_ready !== 4'b1100) begin errors++; $display("FAIL fl_after_rr got %b want 1100", req_ready); end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        flush_req = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rmf_start got %b want 0011", req_ready); end
        @(negedge clk);
        flush_req = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (fifo_clear !== 1'b1) begin errors++; $display("FAIL rmf_clear got %b want 1", fifo_clear); end
        rst = 1'b1;
        #1;
        checks++; if ({fifo_clear, busy, req_ready} !== 6'b000000) begin errors++; $display("FAIL rmf_rst got %b want 000000", {fifo_clear, busy, req_ready}); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({flush_done, busy} !== 2'b00) begin errors++; $display("FAIL rmf_nodone got %b want 00", {flush_done, busy}); end
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rmf_rr got %b want 0011", req_ready); end
`ifdef MULTI_FIFO_PUSH_ARB_STAT_EN
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rmf_stall got %0d want 0", stall_cnt); end
`endif
        @(negedge clk);
        #1;
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL rmf_nodone2 got %b want 0", flush_done); end
    endtask

    initial begin
        req_valid = '0;
        req_num   = '0;
        req_data  = '0;
        test_reset();
        test_basic_pack();
        test_space_skip();
        test_urgent();
        test_lane_skip();
        test_illegal();
        test_flush();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_fifo_push_arb.md
Name: multi_fifo_push_arb

Overview:
- Round-robin push arbiter that shares one multi-push FIFO (M push lanes, DEPTH entries) among R requesters.
- Each requester offers an all-or-nothing burst of 1..M entries per cycle.
- The arbiter packs granted bursts contiguously onto push lanes 0..M-1, so the FIFO never sees a gapped push vector.
- It also owns starvation protection and the FIFO flush sequence. It sits directly in front of the FIFO's push side; pops are unaffected.

Parameters:
- T, logic [7:0], entry data type.
- R, 4, number of requesters.
- M, 4, FIFO push lanes; max burst per requester.
- DEPTH, 16, FIFO depth.
- MAXWAIT, 8, denied cycles before a requester becomes urgent (>=1).
- Derived: DB = $clog2(DEPTH); NB = $clog2(M+1); RB = max(1, $clog2(R)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  R  requester k has a burst.
- req_num  in  R x NB  burst size of requester k.
- req_data  in  R x M x T  burst data; element 0 is first in order.
- req_ready  out  R  burst k accepted this cycle (valid & ready = transfer).
- fifo_push  out  M  push vector to FIFO.
- fifo_datain  out  M x T  push data to FIFO.
- fifo_entry_count  in  DB+1  FIFO registered occupancy.
- flush_req  in  1  request FIFO flush (single-cycle pulse).
- fifo_clear  out  1  clear to FIFO.
- flush_done  out  1  one-cycle pulse, flush complete.
- busy  out  1  flush sequence in progress.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - state = RUN, rr_ptr = 0, all wait counters = 0, flush_done = 0.
  - While rst is high, req_ready, fifo_push, fifo_clear and busy are forced to 0 combinationally.
- Grant (RUN only): combinational, zero latency from req_valid to req_ready and fifo_push.
  - free = DEPTH - fifo_entry_count. Pops in the same cycle are ignored, which is conservative.
  - lanes_left starts at M; space_left starts at free.
  - Scan requesters in order rr_ptr, rr_ptr+1, ..., wrapping mod R.
  - Requester k is eligible when req_valid[k] = 1 and 1 <= req_num[k] <= M.
  - Valid with req_num 0 or > M is illegal: never granted, does not count as waiting.
  - An eligible k is granted iff req_num[k] <= lanes_left and req_num[k] <= space_left. Both budgets then decrease by req_num[k].
  - A non-fitting eligible requester is skipped and the scan continues.
- Urgent override: if any eligible requester has wait == MAXWAIT, the scan begins at the first urgent requester at or after rr_ptr.
  - If that requester does not fit, no requester is granted that cycle.
- Lane packing: a granted burst occupies consecutive lanes in scan order starting at lane 0. Element j of the burst goes on lane base+j.
  - fifo_push = (1 << total_granted) - 1.
  - Unused lanes drive fifo_datain = '0.
- rr_ptr: on any grant, rr_ptr <= (last granted index + 1) mod R; otherwise it holds.
- Wait counters: per requester.
  - Increment (saturating at MAXWAIT) when eligible and not granted.
  - Clear on grant.
  - Hold when not eligible.
- FSM:
  - RUN: flush_req = 1 moves to HOLD. Grants in the same cycle as flush_req still occur.
  - HOLD: req_ready = 0, fifo_push = 0, busy = 1. Moves unconditionally to CLEAR.
  - CLEAR: fifo_clear = 1, busy = 1, no grants. On exit, rr_ptr and all wait counters reset to 0, state moves to RUN, and flush_done pulses in the first RUN cycle.
  - flush_req during HOLD or CLEAR is ignored.
- Reset mid-flush: state returns to RUN immediately. flush_done is not generated.

Optional Feature:
- Macro: MULTI_FIFO_PUSH_ARB_STAT_EN.
- Defined: adds output stall_cnt [15:0], a saturating counter.
  - Increments each RUN cycle in which at least one eligible requester is not granted.
  - Reset to 0 by rst and by the CLEAR state.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
1. Empty FIFO (count 0), rr_ptr = 0, req0 num 2 (A,B), req1 num 2 (C,D) -> req_ready = 0011, fifo_push = 1111, lanes = A,B,C,D; next rr_ptr = 2.
2. count 14, req0 num 3, req1 num 2 -> req0 skipped, req1 on lanes 0-1, fifo_push = 0011; wait0 = 1.
3. Repeat test 2 stimulus until wait0 = 8 -> req0 urgent, nothing granted while count = 14; set count 13 -> req0 granted (fifo_push = 0111), wait0 = 0.
4. rr_ptr = 3, req3 num 1, req0 num 4 -> req3 on lane 0; req0 does not fit (3 lanes left) and is skipped; fifo_push = 0001, rr_ptr = 0.
5. flush_req pulse at cycle t with all requesters valid -> t+1 HOLD with req_ready = 0; t+2 fifo_clear = 1; t+3 flush_done = 1, rr_ptr = 0, waits = 0, grants resume.
6. Assert rst during CLEAR -> fifo_clear and busy drop in the same cycle, state RUN, no flush_done; with the STAT_EN macro defined, stall_cnt = 0.
